// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO on the OpenMIPS data bus.
// Define UART_TX_INT_EN to implement CTRL.IE and the uart_int output.
module uart_tx_periph #(
   parameter int          FIFO_DEPTH  = 4,
   parameter int          DIV_W       = 16,
   parameter int unsigned DEFAULT_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        txd,
   output logic        uart_int
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] tmr_q, tmr_d;
   logic [1:0]       st_q, st_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             txd_q, txd_d;

   logic       wr_en, push, push_ok, pop;
   logic       full, empty, busy, tick, ie_rd;
   logic [1:0] a;
   logic       unused_bits;

   assign a       = addr[3:2];
   assign wr_en   = ce && we;
   assign push    = wr_en && (a == 2'd0) && sel[0];
   assign full    = (cnt_q == CW'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_ok = push && !full;
   assign busy    = (st_q != S_IDLE);
   assign tick    = (tmr_q == '0);
   assign txd     = txd_q;

   assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:8], sel[3:1]};

   assign cnt_d = cnt_q + CW'(push_ok) - CW'(pop);

   always_comb begin
      div_d = div_q;
      if (wr_en && a == 2'd2) begin
         for (int i = 0; i < DIV_W; i++) begin
            if (sel[i/8]) div_d[i] = data_i[i];
         end
      end
   end

   // A drop in the same cycle as a clear leaves overflow set.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_en && a == 2'd3 && sel[0] && data_i[1]) ovf_d = 1'b0;
      if (push && full) ovf_d = 1'b1;
   end

   always_comb begin
      st_d  = st_q;
      bit_d = bit_q;
      sh_d  = sh_q;
      txd_d = txd_q;
      tmr_d = tmr_q;
      pop   = 1'b0;
      if (busy) tmr_d = tick ? div_q : tmr_q - DIV_W'(1);
      unique case (st_q)
         S_IDLE: begin
            if (!empty) begin
               pop   = 1'b1;
               st_d  = S_START;
               txd_d = 1'b0;
               sh_d  = mem_q[rptr_q];
               tmr_d = div_q;
            end
         end
         S_START: begin
            if (tick) begin
               st_d  = S_DATA;
               bit_d = 3'd0;
               txd_d = sh_q[0];
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  st_d  = S_STOP;
                  txd_d = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  txd_d = sh_q[bit_q + 3'd1];
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (!empty) begin
                  pop   = 1'b1;
                  st_d  = S_START;
                  txd_d = 1'b0;
                  sh_d  = mem_q[rptr_q];
               end else begin
                  st_d  = S_IDLE;
               end
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   // Storage is not reset; the pointers and count flush it.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= data_i[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         div_q  <= DIV_W'(DEFAULT_DIV);
         tmr_q  <= '0;
         st_q   <= S_IDLE;
         bit_q  <= '0;
         sh_q   <= '0;
         txd_q  <= 1'b1;
      end else begin
         if (push_ok) wptr_q <= wptr_q + PW'(1);
         if (pop)     rptr_q <= rptr_q + PW'(1);
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         div_q  <= div_d;
         tmr_q  <= tmr_d;
         st_q   <= st_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         txd_q  <= txd_d;
      end
   end

`ifdef UART_TX_INT_EN
   logic ie_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ie_q <= 1'b0;
      end else if (wr_en && a == 2'd3 && sel[0]) begin
         ie_q <= data_i[0];
      end
   end

   assign ie_rd    = ie_q;
   assign uart_int = ie_q && empty && !busy;
`else
   assign ie_rd    = 1'b0;
   assign uart_int = 1'b0;
`endif

   always_comb begin
      data_o = '0;
      if (ce) begin
         unique case (1'b1)
            (a == 2'd1): data_o = {23'd0, empty, full, ovf_q, busy, 5'(cnt_q)};
            (a == 2'd2): data_o = 32'(div_q);
            (a == 2'd3): data_o = {31'd0, ie_rd};
            default:     data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with a txd/busy scoreboard.
// Interrupt expectations follow UART_TX_INT_EN.
module tb_uart_tx_periph;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        txd;
   logic        uart_int;

`ifdef UART_TX_INT_EN
   localparam logic EXP_IE = 1'b1;
`else
   localparam logic EXP_IE = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_q [$];

   uart_tx_periph dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .we       (we),
      .addr     (addr),
      .sel      (sel),
      .data_i   (data_i),
      .data_o   (data_o),
      .txd      (txd),
      .uart_int (uart_int)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] s,
                     input logic [31:0] d);
      ce     = 1'b1;
      we     = 1'b1;
      addr   = {28'd0, a, 2'b00};
      sel    = s;
      data_i = d;
      @(posedge clk);
      #1;
      ce     = 1'b0;
      we     = 1'b0;
      sel    = 4'd0;
      data_i = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      ce   = 1'b1;
      we   = 1'b0;
      addr = {28'd0, a, 2'b00};
      #1;
      d    = data_o;
      ce   = 1'b0;
   endtask

   // Expected {busy, txd} per cycle for one frame.
   task automatic push_frame(input logic [7:0] b, input int div);
      logic bv;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      bv = 1'b0;
         else if (k == 9) bv = 1'b1;
         else             bv = b[k-1];
         repeat (div + 1) exp_q.push_back({1'b1, bv});
      end
   endtask

   task automatic run_stream(input int n);
      logic [1:0]  e;
      logic [31:0] s;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            chk("sb_underrun", 32'(i), 32'(n));
         end else begin
            e = exp_q.pop_front();
            chk("txd", {31'd0, txd}, {31'd0, e[0]});
            rd(2'd1, s);
            chk("busy", {31'd0, s[5]}, {31'd0, e[1]});
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_status(input string tag, input logic [31:0] mask,
                              input logic [31:0] val, input int budget);
      logic [31:0] s;
      logic        ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         rd(2'd1, s);
         if ((s & mask) == val) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk(tag, {31'd0, ok}, 32'd1);
   endtask

   logic [31:0] r;

   initial begin
      rst    = 1'b1;
      ce     = 1'b0;
      we     = 1'b0;
      addr   = '0;
      sel    = '0;
      data_i = '0;
      #2;
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_int", {31'd0, uart_int}, 32'd0);
      chk("rst_data_o", data_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      rd(2'd1, r); chk("status_rst", r, 32'h100);
      rd(2'd2, r); chk("div_rst", r, 32'd16);

      wr(2'd2, 4'b0010, 32'h1234);
      rd(2'd2, r); chk("div_hi_byte", r, 32'h1210);
      wr(2'd0, 4'b0000, 32'h55);
      rd(2'd1, r); chk("push_nosel", r, 32'h100);
      rd(2'd0, r); chk("txdata_rd", r, 32'd0);

      // Abort a frame in DATA with an async reset
      wr(2'd2, 4'b0011, 32'd5);
      wr(2'd0, 4'b0001, 32'h00);
      repeat (10) @(posedge clk);
      #1;
      chk("mid_data_txd", {31'd0, txd}, 32'd0);
      #3;
      rst = 1'b1;
      #1;
      chk("async_txd", {31'd0, txd}, 32'd1);
      rd(2'd1, r); chk("async_status", r, 32'h100);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(2'd2, r); chk("async_div", r, 32'd16);
      chk("async_int", {31'd0, uart_int}, 32'd0);

      // 0xA5 at DIV=3: 10 bits x 4 cycles
      wr(2'd2, 4'b0011, 32'd3);
      exp_q.push_back(2'b01);
      push_frame(8'hA5, 3);
      wr(2'd0, 4'b0001, 32'hA5);
      rd(2'd1, r); chk("a5_count", r, 32'h001);
      run_stream(41);
      chk("a5_sb_left", 32'(exp_q.size()), 32'd0);
      rd(2'd1, r); chk("a5_done", r, 32'h100);
      chk("a5_idle_txd", {31'd0, txd}, 32'd1);

      // Two queued bytes at DIV=1, no gap
      wr(2'd2, 4'b0011, 32'd1);
      push_frame(8'h0F, 1);
      push_frame(8'h80, 1);
      wr(2'd0, 4'b0001, 32'h0F);
      chk("b2b_pre_txd", {31'd0, txd}, 32'd1);
      wr(2'd0, 4'b0001, 32'h80);
      run_stream(40);
      chk("b2b_sb_left", 32'(exp_q.size()), 32'd0);
      rd(2'd1, r); chk("b2b_done", r, 32'h100);

      // FIFO fill and overflow at DIV=0
      wr(2'd2, 4'b0011, 32'd0);
      wr(2'd0, 4'b0001, 32'h11);
      rd(2'd1, r); chk("ff_push1", r, 32'h001);
      wr(2'd0, 4'b0001, 32'h22);
      rd(2'd1, r); chk("ff_pop_e1", r, 32'h021);
      chk("ff_start_txd", {31'd0, txd}, 32'd0);
      wr(2'd0, 4'b0001, 32'h33);
      wr(2'd0, 4'b0001, 32'h44);
      wr(2'd0, 4'b0001, 32'h55);
      rd(2'd1, r); chk("ff_five_ok", r, 32'h0A4);
      wait_status("ff_drain_wait", 32'h1F, 32'h00, 200);
      for (int i = 0; i < 5; i++) wr(2'd0, 4'b0001, 32'(8'h60 + i));
      rd(2'd1, r); chk("ff_overflow", r, 32'h0E4);
      wr(2'd3, 4'b0001, 32'h2);
      rd(2'd1, r); chk("ff_ovf_clr", r, 32'h0A4);
      wait_status("ff_idle_wait", 32'hFFFF_FFFF, 32'h100, 200);

      // Interrupt around one frame at DIV=0
      wr(2'd3, 4'b0001, 32'h1);
      rd(2'd3, r); chk("ctrl_ie_rd", r, {31'd0, EXP_IE});
      chk("int_idle", {31'd0, uart_int}, {31'd0, EXP_IE});
      wr(2'd0, 4'b0001, 32'h3C);
      for (int i = 0; i < 11; i++) begin
         chk("int_frame", {31'd0, uart_int}, 32'd0);
         @(posedge clk);
         #1;
      end
      chk("int_after", {31'd0, uart_int}, {31'd0, EXP_IE});
      rd(2'd1, r); chk("int_status", r, 32'h100);

      addr = 32'h4;
      ce   = 1'b0;
      #1;
      chk("ce_low_data_o", data_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
